// File: rtl/jtoutrun_snd_pkg.sv
// Shared types and constants for the sound ROM arbiter (FSM states, requester indices, bases).
package jtoutrun_snd_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_PCM = 2'd1,
    WAIT_CPU = 2'd2
  } romarb_state_t;

  localparam int unsigned REQ_PCM = 0;
  localparam int unsigned REQ_CPU = 1;

  localparam logic [20:0] PCM_BASE_DEF = 21'h08000;
  localparam logic [20:0] CPU_BASE_DEF = 21'h00000;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/jtoutrun_snd_romarb_if.sv
// Bus bundle for the sound ROM arbiter: PCM and CPU read requests plus the shared SDRAM slot.
interface jtoutrun_snd_romarb_if #(
  parameter int unsigned SDRAM_AW = 21
);
  logic [18:0]         pcm_addr;
  logic                pcm_cs;
  logic [7:0]          pcm_data;
  logic                pcm_ok;
  logic [15:0]         cpu_addr;
  logic                cpu_cs;
  logic [7:0]          cpu_data;
  logic                cpu_ok;
  logic [SDRAM_AW-1:0] sdram_addr;
  logic                sdram_cs;
  logic [15:0]         sdram_data;
  logic                sdram_ok;

  modport slave (
    input  pcm_addr, pcm_cs, cpu_addr, cpu_cs, sdram_data, sdram_ok,
    output pcm_data, pcm_ok, cpu_data, cpu_ok, sdram_addr, sdram_cs
  );

  modport master (
    output pcm_addr, pcm_cs, cpu_addr, cpu_cs, sdram_data, sdram_ok,
    input  pcm_data, pcm_ok, cpu_data, cpu_ok, sdram_addr, sdram_cs
  );
endinterface

// File: rtl/jtoutrun_romarb_cache.sv
// One-word read cache: tag/valid/data, hit compare, byte select and registered ok.
module jtoutrun_romarb_cache #(
  parameter int unsigned         AW       = 19,
  parameter int unsigned         SDRAM_AW = 21,
  parameter logic [SDRAM_AW-1:0] BASE     = '0
) (
  input  logic                rst,
  input  logic                clk,
  input  logic [AW-1:0]       i_addr,
  input  logic                i_cs,
  input  logic                i_fill,
  input  logic [SDRAM_AW-1:0] i_fill_tag,
  input  logic [15:0]         i_fill_data,
  output logic [SDRAM_AW-1:0] o_waddr,
  output logic                o_miss,
  output logic [7:0]          o_data,
  output logic                o_ok
);

  logic                r_valid;
  logic [SDRAM_AW-1:0] r_tag;
  logic [15:0]         r_data;
  logic                w_hit;

  assign o_waddr = BASE + SDRAM_AW'(i_addr[AW-1:1]);
  assign w_hit   = i_cs & r_valid & (r_tag == o_waddr);
  assign o_miss  = i_cs & ~w_hit;
  // Byte lane follows addr[0] without a register so in-word byte changes cost nothing.
  assign o_data  = i_addr[0] ? r_data[15:8] : r_data[7:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
      o_ok    <= 1'b0;
    end else begin
      o_ok <= w_hit;
      if (i_fill) begin
        r_valid <= 1'b1;
        r_tag   <= i_fill_tag;
        r_data  <= i_fill_data;
      end
    end
  end

endmodule

// File: rtl/jtoutrun_snd_romarb.sv
// Sound ROM arbiter: PCM fetcher and sound CPU share one 16-bit SDRAM read slot.
// Optional statistics counters are enabled by defining JTOUTRUN_ROMARB_STATS_EN.
module jtoutrun_snd_romarb
  import jtoutrun_snd_pkg::*;
#(
  parameter int unsigned         SDRAM_AW = 21,
  parameter logic [SDRAM_AW-1:0] PCM_BASE = SDRAM_AW'(PCM_BASE_DEF),
  parameter logic [SDRAM_AW-1:0] CPU_BASE = SDRAM_AW'(CPU_BASE_DEF)
) (
  input  logic rst,
  input  logic clk,
  jtoutrun_snd_romarb_if.slave bus
`ifdef JTOUTRUN_ROMARB_STATS_EN
  ,
  output logic [7:0] o_stats_dout,
  input  logic [1:0] i_stats_sel
`endif
);

  romarb_state_t       r_state;
  logic                r_sdram_cs;
  logic [SDRAM_AW-1:0] r_sdram_addr;
  logic                r_last_pcm;

  logic [1:0]          w_miss;
  logic [1:0]          w_fill;
  logic [SDRAM_AW-1:0] w_pcm_waddr;
  logic [SDRAM_AW-1:0] w_cpu_waddr;
  logic                w_pick_pcm;

  assign w_fill[REQ_PCM] = (r_state == WAIT_PCM) & bus.sdram_ok;
  assign w_fill[REQ_CPU] = (r_state == WAIT_CPU) & bus.sdram_ok;
  // PCM wins unless it was served last and the CPU is also waiting.
  assign w_pick_pcm = w_miss[REQ_PCM] & ~(r_last_pcm & w_miss[REQ_CPU]);

  assign bus.sdram_cs   = r_sdram_cs;
  assign bus.sdram_addr = r_sdram_addr;

  jtoutrun_romarb_cache #(
    .AW       (19),
    .SDRAM_AW (SDRAM_AW),
    .BASE     (PCM_BASE)
  ) u_pcm_cache (
    .rst         (rst),
    .clk         (clk),
    .i_addr      (bus.pcm_addr),
    .i_cs        (bus.pcm_cs),
    .i_fill      (w_fill[REQ_PCM]),
    .i_fill_tag  (r_sdram_addr),
    .i_fill_data (bus.sdram_data),
    .o_waddr     (w_pcm_waddr),
    .o_miss      (w_miss[REQ_PCM]),
    .o_data      (bus.pcm_data),
    .o_ok        (bus.pcm_ok)
  );

  jtoutrun_romarb_cache #(
    .AW       (16),
    .SDRAM_AW (SDRAM_AW),
    .BASE     (CPU_BASE)
  ) u_cpu_cache (
    .rst         (rst),
    .clk         (clk),
    .i_addr      (bus.cpu_addr),
    .i_cs        (bus.cpu_cs),
    .i_fill      (w_fill[REQ_CPU]),
    .i_fill_tag  (r_sdram_addr),
    .i_fill_data (bus.sdram_data),
    .o_waddr     (w_cpu_waddr),
    .o_miss      (w_miss[REQ_CPU]),
    .o_data      (bus.cpu_data),
    .o_ok        (bus.cpu_ok)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_sdram_cs   <= 1'b0;
      r_sdram_addr <= '0;
      r_last_pcm   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_pcm) begin
            r_state      <= WAIT_PCM;
            r_sdram_cs   <= 1'b1;
            r_sdram_addr <= w_pcm_waddr;
          end else if (w_miss[REQ_CPU]) begin
            r_state      <= WAIT_CPU;
            r_sdram_cs   <= 1'b1;
            r_sdram_addr <= w_cpu_waddr;
          end
        end
        WAIT_PCM: begin
          if (bus.sdram_ok) begin
            r_state    <= IDLE;
            r_sdram_cs <= 1'b0;
            r_last_pcm <= 1'b1;
          end
        end
        WAIT_CPU: begin
          if (bus.sdram_ok) begin
            r_state    <= IDLE;
            r_sdram_cs <= 1'b0;
            r_last_pcm <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef JTOUTRUN_ROMARB_STATS_EN
  // 0: PCM misses, 1: CPU misses, 2: PCM stall cycles behind CPU, 3: max PCM miss latency.
  logic [7:0] r_stat [4];
  logic [7:0] r_pcm_lat;
  logic [7:0] w_pcm_lat_nx;

  assign w_pcm_lat_nx = sat_inc8(r_pcm_lat);
  assign o_stats_dout = r_stat[i_stats_sel];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_stat[i] <= '0;
      r_pcm_lat <= '0;
    end else begin
      if (r_state == IDLE && w_pick_pcm) r_stat[0] <= sat_inc8(r_stat[0]);
      if (r_state == IDLE && !w_pick_pcm && w_miss[REQ_CPU]) r_stat[1] <= sat_inc8(r_stat[1]);
      if (r_state == WAIT_CPU && w_miss[REQ_PCM]) r_stat[2] <= sat_inc8(r_stat[2]);
      if (w_fill[REQ_PCM]) begin
        if (w_pcm_lat_nx > r_stat[3]) r_stat[3] <= w_pcm_lat_nx;
        r_pcm_lat <= '0;
      end else if (w_miss[REQ_PCM]) begin
        r_pcm_lat <= w_pcm_lat_nx;
      end else begin
        r_pcm_lat <= '0;
      end
    end
  end
`endif

endmodule

// File: doc/jtoutrun_snd_romarb.md
Name: jtoutrun_snd_romarb

Overview:
- Shares one 16-bit SDRAM read port between two requesters: the PCM sample fetcher (19-bit byte address, bursty, time-critical) and the sound CPU program ROM (16-bit byte address).
- Each requester has a one-word hit cache, so repeated byte reads within a word never reach SDRAM.
- Placed between the PCM engine / sound Z80 and the SDRAM controller slot.

Parameters:
- SDRAM_AW, 21: SDRAM word-address width.
- PCM_BASE, 21'h08000: word offset of the PCM sample region in SDRAM.
- CPU_BASE, 21'h00000: word offset of the CPU program region in SDRAM.

Ports:
- rst  in  1  reset, asynchronous, active-high
- clk  in  1  clock; everything on posedge clk, no clock enable
- pcm_addr  in  19  PCM byte address
- pcm_cs  in  1  PCM request, held until pcm_ok
- pcm_data  out  8  PCM byte
- pcm_ok  out  1  pcm_data valid for current pcm_addr
- cpu_addr  in  16  CPU byte address
- cpu_cs  in  1  CPU request, held until cpu_ok
- cpu_data  out  8  CPU byte
- cpu_ok  out  1  cpu_data valid for current cpu_addr
- sdram_addr  out  SDRAM_AW  word address
- sdram_cs  out  1  SDRAM request
- sdram_data  in  16  SDRAM word, little-endian: byte 0 = [7:0]
- sdram_ok  in  1  sdram_data valid; one-cycle pulse or level while sdram_cs is held

Behaviour:
- Word address:
  - PCM: PCM_BASE + pcm_addr[18:1]
  - CPU: CPU_BASE + cpu_addr[15:1]
  - Sums are truncated to SDRAM_AW.
  - Byte select is addr[0]: 1 selects [15:8].
- Cache per requester: tag (word addr), valid bit, 16-bit data.
- Hit = cs & valid & tag==current word address.
  - On a hit, ok=1 on the next cycle; data is the selected byte of the cached word; no SDRAM access.
- ok is registered every cycle as (cs & hit).
  - It drops one cycle after cs falls or the address leaves the cached word.
  - A byte change within the same word keeps ok high; data follows addr[0] combinationally from the cached word.
- FSM states:
  - IDLE:
    - Pick a missing requester. PCM has priority unless the fairness flag last_pcm=1 and the CPU is also missing.
    - Drive sdram_addr and sdram_cs=1 from the next cycle.
    - Go to WAIT_PCM or WAIT_CPU.
  - WAIT_x:
    - Hold sdram_addr and sdram_cs.
    - On sdram_ok: write the word into cache x, set tag and valid, drop sdram_cs, set last_pcm = (x==PCM), return to IDLE.
- Miss latency: 1 cycle to grant, then SDRAM latency, then 1 cycle to fill. ok rises 1 cycle after the fill, through the hit path.
- Fairness: after a PCM grant, a pending CPU miss is served next; the PCM cannot starve the CPU for more than one transaction.
- Address or cs change during WAIT_x:
  - The transaction completes and fills the cache with the original tag.
  - ok is not asserted unless the new address matches that tag.
  - A mismatch causes a new miss.
- Requester dropping cs mid-transaction: no abort; the fill still happens.
- Simultaneous misses in IDLE: the priority rule above decides; the loser waits in IDLE for the next cycle.
- Reset, including mid-transaction:
  - sdram_cs=0, sdram_addr=0, pcm_ok=0, cpu_ok=0, pcm_data=0, cpu_data=0.
  - Both valid bits are cleared, last_pcm=0, state=IDLE.
  - A late sdram_ok after reset is ignored.
- sdram_ok while in IDLE: ignored.

Optional Feature:
- Macro: JTOUTRUN_ROMARB_STATS_EN.
- Defined:
  - Adds output stats_dout[7:0] and input stats_sel[1:0].
  - Saturating 8-bit counters: 0 = PCM misses, 1 = CPU misses, 2 = cycles the PCM waited while the CPU owned SDRAM, 3 = max PCM miss latency in cycles.
  - Counters clear on rst.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package jtoutrun_snd_pkg:
  - FSM state enum (IDLE, WAIT_PCM, WAIT_CPU).
  - Requester index constants REQ_PCM=0, REQ_CPU=1.
  - Default PCM_BASE/CPU_BASE constants.
- One natural sub-module, jtoutrun_romarb_cache:
  - One-word tag/valid/data store with hit compare, byte select and registered ok.
  - Instantiated twice with different address widths.

Test Plan:
- PCM reads 0x00010 then 0x00011 (SDRAM returns 16'hBEEF after 3 cycles) -> one sdram_cs with sdram_addr=PCM_BASE+8; pcm_data=0xEF then 0xBE; the second byte is a hit with ok=1 the next cycle.
- PCM and CPU miss on the same cycle, last_pcm=0 -> PCM granted first, CPU second; a new PCM miss then arrives during the CPU wait -> it waits until the CPU fill completes.
- Back-to-back PCM misses with a CPU miss pending -> order PCM, CPU, PCM; the CPU wait is bounded by one PCM transaction.
- cpu_addr changes 0x1234 -> 0x5678 during WAIT_CPU -> fill tagged 0x091A; cpu_ok stays 0; a second request goes to word 0x2B3C; cpu_ok follows.
- rst asserted while sdram_cs=1, sdram_ok pulses 1 cycle after release -> outputs stay 0; the next PCM request to the same address misses.
- With JTOUTRUN_ROMARB_STATS_EN defined: 300 PCM misses -> stats_sel=0 reads 0xFF (saturated).
